// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer_irq peripheral: register offsets, CTRL bit
// positions, the interrupt-flag bit the SoC assigns to this timer, and the
// packed CTRL layout used by the RTL.
package timer_irq_pkg;

  // Byte offsets of the registers.
  localparam logic [3:0] TIMER_CTRL  = 4'h0;
  localparam logic [3:0] TIMER_COUNT = 4'h4;
  localparam logic [3:0] TIMER_CMP   = 4'h8;
  localparam logic [3:0] TIMER_PSC   = 4'hC;

  // CTRL bit indices.
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_IE   = 1;
  localparam int unsigned CTRL_PEND = 2;
  localparam int unsigned CTRL_MODE = 3;

  // Bit of the core interrupt-flag input driven by int_sig_o.
  localparam int unsigned TIMER_IRQ_IDX = 7;

  // Word select taken from addr[3:2].
  typedef enum logic [1:0] {
    RegCtrl  = 2'd0,
    RegCount = 2'd1,
    RegCmp   = 2'd2,
    RegPsc   = 2'd3
  } reg_sel_e;

  // Field order matches the CTRL bit indices above (en is bit 0).
  typedef struct packed {
    logic mode;
    logic pend;
    logic ie;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    return {28'b0, c};
  endfunction

endpackage

// File: rtl/timer_irq_prescaler.sv
// timer_prescaler: tick generator for the timer counter.
// Emits tick_o once every psc_i+1 enabled cycles. The phase counter is held at
// zero while disabled, so an enable rising edge always restarts the period,
// and clr_i (a PSC write) restarts it as well.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   en_i      timer enable (CTRL.EN)
//   clr_i     restart the prescale period
//   psc_i     prescale divisor minus one
//   tick_o    count-enable pulse for the timer
module timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [15:0] psc_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;

  // >= guards against a phase past the divisor; a PSC write also clears it.
  assign tick_o = en_i && (cnt_q >= psc_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped machine timer with a level interrupt output.
// Software programs CMP and CTRL; the counter runs while EN is set, sets PEND
// on COUNT==CMP, and int_sig_o follows PEND & IE one cycle later until
// software clears PEND (write 1 to CTRL[2]) or IE.
// Optional build macro TIMER_PRESCALER_EN adds the PSC register at offset 0xC
// and a prescaled tick; without it the timer ticks every cycle and offset 0xC
// reads zero.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   req_i      one-cycle access strobe
//   we_i       1 = write, 0 = read
//   addr_i     byte address, bits [3:2] select the register
//   wdata_i    write data
//   rdata_o    registered read data, zero outside ack cycles
//   ack_o      access complete, one cycle after req_i
//   int_sig_o  registered interrupt request
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter logic [31:0] CNT_RST_CMP = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  output logic              int_sig_o
);

  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q;
  logic        int_q;

  reg_sel_e    sel;
  logic        wr_ctrl, wr_count, wr_cmp, wr_psc;
  logic        tick;
  logic        run;
  logic        match;
  logic [31:0] psc_word;

  // Only addr[3:2] decode; the remaining address bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^addr_i;

  assign sel      = reg_sel_e'(addr_i[3:2]);
  assign wr_ctrl  = req_i && we_i && (sel == RegCtrl);
  assign wr_count = req_i && we_i && (sel == RegCount);
  assign wr_cmp   = req_i && we_i && (sel == RegCmp);
  assign wr_psc   = req_i && we_i && (sel == RegPsc);

`ifdef TIMER_PRESCALER_EN
  logic [15:0] psc_q;

  timer_prescaler u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en_i   (ctrl_q.en),
    .clr_i  (wr_psc),
    .psc_i  (psc_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q <= '0;
    end else if (wr_psc) begin
      psc_q <= wdata_i[15:0];
    end
  end

  assign psc_word = {16'b0, psc_q};
`else
  logic unused_wr_psc;
  assign unused_wr_psc = wr_psc;
  assign tick          = 1'b1;
  assign psc_word      = '0;
`endif

  // A COUNT write in the same cycle suppresses both increment and compare.
  assign run   = ctrl_q.en && tick && !wr_count;
  assign match = run && (count_q == cmp_q);

  always_comb begin
    ctrl_d  = ctrl_q;
    count_d = count_q;
    cmp_d   = cmp_q;

    if (run) begin
      if (match) begin
        count_d = '0;
        if (!ctrl_q.mode) begin
          ctrl_d.en = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_count) begin
      count_d = wdata_i;
    end
    if (wr_cmp) begin
      cmp_d = wdata_i;
    end
    // Software EN write overrides a one-shot auto-clear in the same cycle.
    if (wr_ctrl) begin
      ctrl_d.en   = wdata_i[CTRL_EN];
      ctrl_d.ie   = wdata_i[CTRL_IE];
      ctrl_d.mode = wdata_i[CTRL_MODE];
      if (wdata_i[CTRL_PEND]) begin
        ctrl_d.pend = 1'b0;
      end
    end
    // Hardware set beats the W1C so a coincident match is not lost.
    if (match) begin
      ctrl_d.pend = 1'b1;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (req_i && !we_i) begin
      unique case (sel)
        RegCtrl:  rdata_d = ctrl_to_word(ctrl_q);
        RegCount: rdata_d = count_q;
        RegCmp:   rdata_d = cmp_q;
        RegPsc:   rdata_d = psc_word;
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= CNT_RST_CMP;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      rdata_q <= rdata_d;
      ack_q   <= req_i;
      int_q   <= ctrl_q.pend && ctrl_q.ie;
    end
  end

  assign rdata_o   = rdata_q;
  assign ack_o     = ack_q;
  assign int_sig_o = int_q;

endmodule

// File: tb/tb_timer_irq.sv
module tb_timer_irq;
  import timer_irq_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        int_sig_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [127:0] name;
    bit           chk_data;
    logic [31:0]  data;
    logic         irq;
  } exp_t;

  exp_t sb_q[$];

  timer_irq u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .ack_o     (ack_o),
    .int_sig_o (int_sig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples on the falling edge, pops an expectation on every ack.
  logic req_prev = 1'b0;
  logic rst_prev = 1'b0;
  exp_t e;

  initial begin
    forever begin
      @(negedge clk);
      total++;
      if (ack_o !== (req_prev & ~rst_prev)) begin
        bad++;
        $display("FAIL ack_timing: got %b want %b at %0t", ack_o, req_prev & ~rst_prev, $time);
      end
      if (rst_prev) begin
        total++;
        if (int_sig_o !== 1'b0) begin
          bad++;
          $display("FAIL int_after_rst: got %b want 0", int_sig_o);
        end
      end
      if (ack_o === 1'b1) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          if (e.chk_data && rdata_o !== e.data) begin
            bad++;
            $display("FAIL %0s rdata: got %h want %h", e.name, rdata_o, e.data);
          end
          if (int_sig_o !== e.irq) begin
            bad++;
            $display("FAIL %0s int_sig: got %b want %b", e.name, int_sig_o, e.irq);
          end
        end
      end else begin
        total++;
        if (rdata_o !== 32'h0) begin
          bad++;
          $display("FAIL rdata_idle: got %h want 0", rdata_o);
        end
      end
      req_prev = req_i;
      rst_prev = rst;
    end
  end

  // Each access occupies exactly one cycle; the caller starts just after a rising edge.
  task automatic acc(input bit we, input logic [3:0] a, input logic [31:0] wd,
                     input bit chkd, input logic [31:0] ed, input logic ei,
                     input logic [127:0] nm);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = a;
    wdata_i = wd;
    sb_q.push_back('{nm, chkd, ed, ei});
    @(posedge clk);
    #1;
    req_i   = 1'b0;
    we_i    = 1'b0;
    wdata_i = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic ei,
                    input logic [127:0] nm);
    acc(1'b1, a, d, 1'b0, 32'h0, ei, nm);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] ed, input logic ei,
                    input logic [127:0] nm);
    acc(1'b0, a, 32'h0, 1'b1, ed, ei, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst     = 1'b1;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values.
    rd(TIMER_CTRL,  32'h0,         1'b0, "rst_ctrl");
    rd(TIMER_COUNT, 32'h0,         1'b0, "rst_count");
    rd(TIMER_CMP,   32'hFFFF_FFFF, 1'b0, "rst_cmp");
    rd(TIMER_PSC,   32'h0,         1'b0, "rst_psc");
    idle(2);

    // Periodic, CMP=3: count 0..3, PEND on match, IRQ a cycle later.
    wr(TIMER_CMP,  32'd3,  1'b0, "per_wr_cmp");
    wr(TIMER_CTRL, 32'hB,  1'b0, "per_wr_ctrl");
    rd(TIMER_COUNT, 32'd0, 1'b0, "per_cnt0");
    rd(TIMER_COUNT, 32'd1, 1'b0, "per_cnt1");
    rd(TIMER_COUNT, 32'd2, 1'b0, "per_cnt2");
    rd(TIMER_COUNT, 32'd3, 1'b0, "per_cnt3");
    rd(TIMER_COUNT, 32'd0, 1'b1, "per_wrap");
    rd(TIMER_CTRL,  32'hF, 1'b1, "per_ctrl");
    rd(TIMER_COUNT, 32'd2, 1'b1, "per_cnt2b");
    // W1C on the exact match cycle: PEND survives, EN/IE drop.
    wr(TIMER_CTRL, 32'h4,  1'b1, "w1c_match");
    rd(TIMER_CTRL, 32'h4,  1'b0, "w1c_set_wins");
    wr(TIMER_CTRL, 32'h4,  1'b0, "w1c_clear");
    rd(TIMER_CTRL, 32'h0,  1'b0, "w1c_cleared");
    rd(TIMER_COUNT, 32'd0, 1'b0, "stop_count");

    // One-shot, CMP=5: single PEND, EN auto-clears, COUNT parks at 0.
    wr(TIMER_CMP,  32'd5, 1'b0, "os_wr_cmp");
    wr(TIMER_CTRL, 32'h3, 1'b0, "os_wr_ctrl");
    idle(8);
    rd(TIMER_CTRL,  32'h6, 1'b1, "os_ctrl");
    rd(TIMER_COUNT, 32'h0, 1'b1, "os_count");
    wr(TIMER_CTRL,  32'h6, 1'b1, "os_w1c");
    rd(TIMER_CTRL,  32'h2, 1'b0, "os_irq_fall");
    rd(TIMER_COUNT, 32'h0, 1'b0, "os_count_hold");

    // Wrap modulo 2^32 and COUNT write beating a tick.
    wr(TIMER_COUNT, 32'hFFFF_FFFF, 1'b0, "wrap_wr_cnt");
    wr(TIMER_CTRL,  32'h9,         1'b0, "wrap_wr_ctrl");
    rd(TIMER_COUNT, 32'hFFFF_FFFF, 1'b0, "wrap_max");
    rd(TIMER_COUNT, 32'h0,         1'b0, "wrap_zero");
    wr(TIMER_COUNT, 32'h100,       1'b0, "cnt_wr_wins");
    rd(TIMER_COUNT, 32'h100,       1'b0, "cnt_wr_val");
    rd(TIMER_COUNT, 32'h101,       1'b0, "cnt_wr_inc");
    wr(TIMER_CTRL,  32'h0,         1'b0, "wrap_stop");
    rd(TIMER_CTRL,  32'h0,         1'b0, "wrap_ctrl");

`ifdef TIMER_PRESCALER_EN
    // PSC=2, CMP=1: COUNT steps every 3 cycles, PEND after 6.
    wr(TIMER_PSC,   32'd2, 1'b0, "psc_wr");
    wr(TIMER_CMP,   32'd1, 1'b0, "psc_wr_cmp");
    wr(TIMER_COUNT, 32'd0, 1'b0, "psc_wr_cnt");
    wr(TIMER_CTRL,  32'h1, 1'b0, "psc_wr_ctrl");
    rd(TIMER_COUNT, 32'd0, 1'b0, "psc_c0");
    rd(TIMER_COUNT, 32'd0, 1'b0, "psc_c1");
    rd(TIMER_COUNT, 32'd0, 1'b0, "psc_c2");
    rd(TIMER_COUNT, 32'd1, 1'b0, "psc_c3");
    rd(TIMER_COUNT, 32'd1, 1'b0, "psc_c4");
    rd(TIMER_COUNT, 32'd1, 1'b0, "psc_c5");
    rd(TIMER_CTRL,  32'h4, 1'b0, "psc_pend");
    rd(TIMER_COUNT, 32'd0, 1'b0, "psc_c_end");
    rd(TIMER_PSC,   32'd2, 1'b0, "psc_rd");
    wr(TIMER_CTRL,  32'h4, 1'b0, "psc_w1c");
    wr(TIMER_PSC,   32'd0, 1'b0, "psc_wr0");
`else
    wr(TIMER_PSC, 32'd2, 1'b0, "psc_wr_ign");
    rd(TIMER_PSC, 32'd0, 1'b0, "psc_rd_zero");
`endif

    // Reset mid-count with COUNT=7 and IRQ high; a request in the reset cycle is dropped.
    wr(TIMER_CMP,   32'h20, 1'b0, "rm_wr_cmp");
    wr(TIMER_COUNT, 32'h1F, 1'b0, "rm_wr_cnt");
    wr(TIMER_CTRL,  32'hB,  1'b0, "rm_wr_ctrl");
    idle(8);
    rd(TIMER_COUNT, 32'd6, 1'b1, "rm_pre_rst");
    rst    = 1'b1;
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = TIMER_COUNT;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    req_i = 1'b0;
    rd(TIMER_CTRL,  32'h0,         1'b0, "rm_ctrl");
    rd(TIMER_COUNT, 32'h0,         1'b0, "rm_count");
    rd(TIMER_CMP,   32'hFFFF_FFFF, 1'b0, "rm_cmp");
    rd(TIMER_PSC,   32'h0,         1'b0, "rm_psc");

    idle(3);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
Name: timer_irq

Overview:
- Memory-mapped machine timer peripheral on the SoC data bus.
- Produces the level interrupt request that the core interrupt controller consumes as one bit of its interrupt-flag input.
- Software programs a compare value and mode. The timer counts, sets a pending flag on match and holds its interrupt line until software clears it, typically inside the trap handler before mret.

Parameters:
- ADDR_W, 4, width of the local register address (word-aligned, bits [3:2] decode).
- CNT_RST_CMP, 32'hFFFF_FFFF, reset value of the compare register.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req_i  in  1  bus access strobe, one cycle per access.
- we_i  in  1  1 = write, 0 = read (qualified by req_i).
- addr_i  in  ADDR_W  byte address; [1:0] ignored.
- wdata_i  in  32  write data (full word only).
- rdata_o  out  32  read data, registered.
- ack_o  out  1  access complete, one cycle after req_i.
- int_sig_o  out  1  interrupt request to the controller, registered.

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - rdata_o=0, ack_o=0, int_sig_o=0.
  - CTRL=0, COUNT=0, CMP=CNT_RST_CMP.
- Register map (addr[3:2]):
  - 0 CTRL: [0] EN; [1] IE; [2] PEND (read-only status; writing 1 clears it, writing 0 has no effect); [3] MODE (0 = one-shot, 1 = periodic); [31:4] read 0.
  - 1 COUNT: read/write.
  - 2 CMP: read/write.
  - 3 PSC: see Optional Feature.
- Bus handshake:
  - Each req_i cycle is answered with ack_o=1 in the next cycle. No wait states; back-to-back requests are allowed.
  - A read returns the register value as it stood in the req_i cycle, on rdata_o in the ack_o cycle. rdata_o=0 when ack_o=0.
  - Writes take effect at the end of the req_i cycle.
  - Unmapped address: read returns 0, write is ignored.
- Counting (when EN=1 and tick=1; tick is 1 every cycle unless prescaled):
  - If COUNT==CMP: COUNT<=0 and PEND<=1. In one-shot mode, EN<=0 as well.
  - Otherwise COUNT<=COUNT+1, wrapping modulo 2^32.
- EN=0: COUNT holds.
- int_sig_o <= PEND & IE, so it goes high one cycle after PEND is set. It stays level until PEND is cleared or IE is cleared.
- Simultaneous events:
  - Software write to COUNT in the same cycle as a tick: the write wins; no increment and no match check that cycle.
  - Write of CMP: takes effect for the next cycle's compare.
  - Write CTRL with PEND=1 in the same cycle as a match: set wins, so the event is not lost.
  - Write CTRL with EN=1 in the same cycle as a one-shot auto-clear: the write wins.
- CMP=0 in periodic mode: PEND is set on every tick.
- Reset mid-operation: all state returns to reset values in the next cycle, and any in-flight ack is dropped.

Optional Feature:
- Macro: TIMER_PRESCALER_EN.
- Defined:
  - PSC register (16 bits, [15:0], reset 0) at addr[3:2]=3.
  - A 16-bit prescale counter generates tick=1 once every PSC+1 enabled cycles. It resets to 0 on EN 0->1 and on any PSC write.
- Undefined:
  - tick=1 every cycle.
  - addr 3 reads 0 and writes are ignored.

Decomposition:
- Shared package/defines:
  - Register offsets: TIMER_CTRL=4'h0, TIMER_COUNT=4'h4, TIMER_CMP=4'h8, TIMER_PSC=4'hC.
  - CTRL bit indices (EN, IE, PEND, MODE).
  - The interrupt-flag bit index the SoC assigns to this timer.
- Sub-module: timer_prescaler (tick generator). Instantiated only under TIMER_PRESCALER_EN.

Test Plan:
- Reset, then read all four addresses -> CTRL=0, COUNT=0, CMP=FFFF_FFFF, PSC=0. ack_o one cycle after each req_i.
- CMP=3, CTRL=0xB (EN|IE|periodic) -> COUNT 0,1,2,3,0; PEND set when 3 matches; int_sig_o high the following cycle; pattern repeats every 4 cycles.
- One-shot, CMP=5, EN|IE -> single PEND after 6 cycles; EN reads 0; COUNT stays 0.
- Write CTRL=0x4 (W1C) -> int_sig_o falls one cycle later. Issue the W1C on the exact match cycle -> PEND stays 1.
- TIMER_PRESCALER_EN, PSC=2, CMP=1, EN -> COUNT increments every 3 cycles; PEND after 6 cycles.
- Assert rst mid-count with COUNT=7 and int_sig_o=1 -> next cycle all outputs 0 and registers at reset values.
